// File: rtl/mms_seq_ctrl.sv
// Sequential min/max search over COUNT unsigned operands with a valid/ready
// operand input and a held, registered result handshake.
module mms_seq_ctrl #(
  parameter int WIDTH = 8,
  parameter int COUNT = 8
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     clear,
  input  logic                     start,
  input  logic                     select,
  input  logic                     in_valid,
  input  logic [WIDTH-1:0]         in_data,
  output logic                     in_ready,
  output logic                     busy,
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic [WIDTH-1:0]         result,
  output logic [$clog2(COUNT)-1:0] result_idx
);

  localparam int IW = $clog2(COUNT);
  localparam logic [IW-1:0] LAST_IDX = IW'(COUNT - 1);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    COLLECT = 2'd1,
    DONE    = 2'd2
  } state_t;

  state_t           state_r;
  state_t           state_s;
  logic             mode_r;
  logic [IW-1:0]    cnt_r;
  logic [WIDTH-1:0] best_r;
  logic [IW-1:0]    idx_r;
  logic [WIDTH-1:0] result_r;
  logic [IW-1:0]    result_idx_r;
  logic             out_valid_r;

  logic             accept_s;
  logic             last_s;
  logic             take_s;
  logic [WIDTH-1:0] new_best_s;
  logic [IW-1:0]    new_idx_s;

  assign in_ready   = (state_r == COLLECT);
  assign busy       = (state_r != IDLE);
  assign out_valid  = out_valid_r;
  assign result     = result_r;
  assign result_idx = result_idx_r;

  // Operand acceptance and running-winner selection (strict compare keeps earliest on ties)
  always_comb begin
    accept_s   = 1'b0;
    last_s     = 1'b0;
    take_s     = 1'b0;
    new_best_s = best_r;
    new_idx_s  = idx_r;
    accept_s   = (state_r == COLLECT) && in_valid;
    last_s     = accept_s && (cnt_r == LAST_IDX);
    if (cnt_r == {IW{1'b0}}) begin
      take_s = 1'b1;
    end else if (mode_r) begin
      take_s = (in_data < best_r);
    end else begin
      take_s = (in_data > best_r);
    end
    if (take_s) begin
      new_best_s = in_data;
      new_idx_s  = cnt_r;
    end else begin
      new_best_s = best_r;
      new_idx_s  = idx_r;
    end
  end

  // Next-state decode; clear overrides every other request
  always_comb begin
    state_s = state_r;
    if (clear) begin
      state_s = IDLE;
    end else begin
      case (state_r)
        IDLE: begin
          if (start) state_s = COLLECT;
          else       state_s = IDLE;
        end
        COLLECT: begin
          if (last_s) state_s = DONE;
          else        state_s = COLLECT;
        end
        DONE: begin
          if (out_ready) state_s = IDLE;
          else           state_s = DONE;
        end
        default: state_s = IDLE;
      endcase
    end
  end

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_r <= IDLE;
    else        state_r <= state_s;
  end

  // Datapath: mode latch, counter, running winner and held result
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mode_r       <= 1'b0;
      cnt_r        <= {IW{1'b0}};
      best_r       <= {WIDTH{1'b0}};
      idx_r        <= {IW{1'b0}};
      result_r     <= {WIDTH{1'b0}};
      result_idx_r <= {IW{1'b0}};
      out_valid_r  <= 1'b0;
    end else if (clear) begin
      cnt_r       <= {IW{1'b0}};
      out_valid_r <= 1'b0;
    end else begin
      if ((state_r == IDLE) && start) begin
        mode_r <= select;
        cnt_r  <= {IW{1'b0}};
      end
      if (accept_s) begin
        best_r <= new_best_s;
        idx_r  <= new_idx_s;
        cnt_r  <= last_s ? {IW{1'b0}} : cnt_r + IW'(1);
      end
      if (last_s) begin
        result_r     <= new_best_s;
        result_idx_r <= new_idx_s;
        out_valid_r  <= 1'b1;
      end
      if ((state_r == DONE) && out_ready) begin
        out_valid_r <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_mms_seq_ctrl.sv
// Self-checking bench for mms_seq_ctrl: directed scenarios plus randomized
// traffic, compared each cycle against a transaction-level queue model.
module tb_mms_seq_ctrl;

  localparam int WIDTH = 8;
  localparam int COUNT = 8;
  localparam int IW    = $clog2(COUNT);

  logic             clk = 1'b0;
  logic             rst_n;
  logic             clear, start, select, in_valid, out_ready;
  logic [WIDTH-1:0] in_data;
  logic             in_ready, busy, out_valid;
  logic [WIDTH-1:0] result;
  logic [IW-1:0]    result_idx;

  int vectors = 0;
  int miscompares = 0;

  // model: phase 0 = waiting for start, 1 = gathering operands, 2 = result offered
  int               m_phase;
  bit               m_mode;
  logic [WIDTH-1:0] ops[$];
  logic [WIDTH-1:0] m_res;
  int               m_idx;
  bit               m_ov;

  mms_seq_ctrl #(.WIDTH(WIDTH), .COUNT(COUNT)) dut (
    .clk(clk), .rst_n(rst_n), .clear(clear), .start(start), .select(select),
    .in_valid(in_valid), .in_data(in_data), .in_ready(in_ready), .busy(busy),
    .out_valid(out_valid), .out_ready(out_ready), .result(result),
    .result_idx(result_idx)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s actual=%0d expected=%0d at %0t", name, act, exp, $time);
    end
  endtask

  function automatic void pick_winner();
    m_res = ops[0];
    m_idx = 0;
    for (int i = 1; i < ops.size(); i++) begin
      if (m_mode ? (ops[i] < m_res) : (ops[i] > m_res)) begin
        m_res = ops[i];
        m_idx = i;
      end
    end
  endfunction

  task automatic model_reset();
    m_phase = 0; m_mode = 1'b0; m_res = '0; m_idx = 0; m_ov = 1'b0;
    ops.delete();
  endtask

  task automatic check_all();
    chk("in_ready",   {31'd0, in_ready},  {31'd0, m_phase == 1});
    chk("busy",       {31'd0, busy},      {31'd0, m_phase != 0});
    chk("out_valid",  {31'd0, out_valid}, {31'd0, m_ov});
    chk("result",     {24'd0, result},    {24'd0, m_res});
    chk("result_idx", {29'd0, result_idx}, m_idx);
  endtask

  // advance one clock: model consumes the inputs applied for this cycle
  task automatic step();
    if (clear) begin
      m_phase = 0; m_ov = 1'b0; ops.delete();
    end else if (m_phase == 0) begin
      if (start) begin m_mode = select; ops.delete(); m_phase = 1; end
    end else if (m_phase == 1) begin
      if (in_valid) begin
        ops.push_back(in_data);
        if (ops.size() == COUNT) begin pick_winner(); m_ov = 1'b1; m_phase = 2; end
      end
    end else begin
      if (out_ready) begin m_phase = 0; m_ov = 1'b0; end
    end
    @(posedge clk);
    #1;
    check_all();
  endtask

  task automatic idle_inputs();
    clear = 1'b0; start = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
    in_data = 8'($urandom);
  endtask

  task automatic do_start(input logic sel);
    start = 1'b1; select = sel; step(); start = 1'b0;
  endtask

  task automatic feed(input logic [WIDTH-1:0] d);
    in_valid = 1'b1; in_data = d; step(); in_valid = 1'b0;
  endtask

  task automatic release_result();
    out_ready = 1'b1; step(); out_ready = 1'b0;
  endtask

  logic [WIDTH-1:0] seq_a[8] = '{8'd3, 8'd200, 8'd17, 8'd200, 8'd9, 8'd0, 8'd255, 8'd1};
  logic [WIDTH-1:0] seq_b[8] = '{8'd50, 8'd7, 8'd90, 8'd7, 8'd7, 8'd60, 8'd8, 8'd100};

  initial begin
    rst_n = 1'b0; select = 1'b0;
    idle_inputs();
    model_reset();
    #1;
    check_all();
    #11 rst_n = 1'b1;
    step();

    // max, back-to-back operands
    do_start(1'b0);
    for (int i = 0; i < 8; i++) feed(seq_a[i]);
    chk("t1_ov", {31'd0, out_valid}, 32'd1);
    chk("t1_res", {24'd0, result}, 32'd255);
    chk("t1_idx", {29'd0, result_idx}, 32'd6);
    release_result();

    // min with ties and bubbles, then 5 cycles of backpressure
    do_start(1'b1);
    for (int i = 0; i < 8; i++) begin
      feed(seq_b[i]);
      if (i < 7) begin in_data = 8'd0; step(); end
    end
    for (int i = 0; i < 5; i++) begin
      step();
      chk("t2_hold_ov", {31'd0, out_valid}, 32'd1);
      chk("t2_hold_rdy", {31'd0, in_ready}, 32'd0);
      chk("t2_res", {24'd0, result}, 32'd7);
      chk("t2_idx", {29'd0, result_idx}, 32'd1);
    end
    // start together with out_ready in DONE must be ignored
    start = 1'b1; out_ready = 1'b1; step();
    start = 1'b0; out_ready = 1'b0;
    chk("t3_ov_drop", {31'd0, out_valid}, 32'd0);
    step();
    chk("t3_idle", {31'd0, busy}, 32'd0);

    // clear mid-search (while an operand is offered), then a fresh max search
    do_start(1'b1);
    for (int i = 0; i < 4; i++) feed(8'd250);
    clear = 1'b1; in_valid = 1'b1; in_data = 8'd255; step();
    clear = 1'b0; in_valid = 1'b0;
    do_start(1'b0);
    for (int i = 1; i <= 8; i++) feed(8'(i));
    chk("t4_res", {24'd0, result}, 32'd8);
    chk("t4_idx", {29'd0, result_idx}, 32'd7);
    release_result();

    // async reset between edges during COLLECT
    do_start(1'b0);
    for (int i = 0; i < 3; i++) feed(8'd99);
    #3 rst_n = 1'b0;
    #1;
    chk("t5_rdy", {31'd0, in_ready}, 32'd0);
    chk("t5_busy", {31'd0, busy}, 32'd0);
    chk("t5_ov", {31'd0, out_valid}, 32'd0);
    chk("t5_res", {24'd0, result}, 32'd0);
    chk("t5_idx", {29'd0, result_idx}, 32'd0);
    model_reset();
    #2 rst_n = 1'b1;
    in_valid = 1'b1;
    for (int i = 0; i < 3; i++) step();
    in_valid = 1'b0;

    // select changes during COLLECT have no effect
    do_start(1'b0);
    select = 1'b1;
    for (int i = 1; i <= 8; i++) feed(8'(i * 10));
    chk("t6_res", {24'd0, result}, 32'd80);
    chk("t6_idx", {29'd0, result_idx}, 32'd7);
    release_result();

    // randomized traffic
    for (int n = 0; n < 1500; n++) begin
      start     = ($urandom_range(0, 3) == 0);
      select    = 1'($urandom);
      in_valid  = ($urandom_range(0, 3) != 0);
      in_data   = ($urandom_range(0, 3) == 0) ? 8'($urandom_range(0, 3)) : 8'($urandom);
      out_ready = ($urandom_range(0, 2) == 0);
      clear     = ($urandom_range(0, 63) == 0);
      step();
    end
    idle_inputs();
    step();

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
